interfaz_tx_scheduler: RTL and testbench

//  Queues ALU results and schedules their transmission on the UART TX.

---
 rtl/interfaz_tx_scheduler_pkg.sv | 21 ++
 rtl/interfaz_tx_scheduler_sync_fifo.sv | 57 +++++
 rtl/interfaz_tx_scheduler.sv | 130 +++++++++++++
 tb/tb_interfaz_tx_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/interfaz_tx_scheduler_pkg.sv
// rtl/interfaz_tx_scheduler_pkg.sv - shared states, defaults and edge helper for the TX scheduler
package interfaz_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_HDR    = 3'd2,
    ST_WAIT_H = 3'd3,
    ST_DATA   = 3'd4,
    ST_WAIT_D = 3'd5,
    ST_GAP    = 3'd6
  } tx_state_e;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Rising-edge convention shared with the RX side: current level high, previous sample low.
  function automatic logic rise_edge(input logic cur, input logic prev);
    return cur && !prev;
  endfunction

endpackage

// File: rtl/interfaz_tx_scheduler_sync_fifo.sv
// rtl/interfaz_tx_scheduler_sync_fifo.sv - synchronous result queue with occupancy count
module sync_fifo #(
  parameter int NB_DATA    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [NB_DATA-1:0]            din,
  output logic [NB_DATA-1:0]            dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [NB_DATA-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LW-1:0]      level_r;
  logic               do_push;
  logic               do_pop;

  assign full    = (level_r == LW'(FIFO_DEPTH));
  assign empty   = (level_r == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full queue may still accept.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = level_r;

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_r <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/interfaz_tx_scheduler.sv
// rtl/interfaz_tx_scheduler.sv - queues ALU results and sends header/result bytes to the UART TX
module interfaz_tx_scheduler
  import interfaz_tx_scheduler_pkg::*;
#(
  parameter int                NB_DATA     = 8,
  parameter int                FIFO_DEPTH  = 4,
  parameter int                SEND_HEADER = 1,
  parameter logic [NB_DATA-1:0] HEADER     = NB_DATA'(HEADER_DEFAULT),
  parameter int                TIMEOUT     = 2**16,
  parameter int                GAP_CYCLES  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NB_DATA-1:0]            i_result,
  input  logic                          i_result_valid,
  input  logic                          i_tx_done,
  output logic [NB_DATA-1:0]            o_tx_data,
  output logic                          o_tx_start,
  output logic                          o_busy,
  output logic                          o_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow,
  output logic                          o_tx_err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  tx_state_e          state;
  tx_state_e          state_next;
  logic [NB_DATA-1:0] result_reg;
  logic [NB_DATA-1:0] tx_data_r;
  logic [TW-1:0]      tmo;
  logic [GW-1:0]      gap_cnt;
  logic               done_prev;
  logic               overflow_r;
  logic               tx_err_r;

  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [NB_DATA-1:0] fifo_dout;
  logic               push_ok;
  logic               done_edge;
  logic               tmo_hit;
  logic               gap_hit;
  logic               waiting;

  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign push_ok   = i_result_valid && (!fifo_full || fifo_pop);
  assign done_edge = rise_edge(i_tx_done, done_prev);
  assign tmo_hit   = (tmo == TMO_LAST);
  assign gap_hit   = (gap_cnt == GAP_LAST);
  assign waiting   = (state == ST_WAIT_H) || (state == ST_WAIT_D);

  sync_fifo #(
    .NB_DATA    (NB_DATA),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (i_result_valid),
    .pop   (fifo_pop),
    .din   (i_result),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (o_level)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (!fifo_empty) state_next = ST_LOAD;
      ST_LOAD:   state_next = (SEND_HEADER != 0) ? ST_HDR : ST_DATA;
      ST_HDR:    state_next = ST_WAIT_H;
      ST_WAIT_H: begin
        if (done_edge)    state_next = ST_DATA;
        else if (tmo_hit) state_next = ST_GAP;
      end
      ST_DATA:   state_next = ST_WAIT_D;
      ST_WAIT_D: begin
        if (done_edge || tmo_hit) state_next = ST_GAP;
      end
      ST_GAP:    if (gap_hit) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      result_reg <= '0;
      tx_data_r  <= '0;
      tmo        <= '0;
      gap_cnt    <= '0;
      done_prev  <= 1'b0;
      overflow_r <= 1'b0;
      tx_err_r   <= 1'b0;
    end else begin
      state     <= state_next;
      done_prev <= i_tx_done;

      if (fifo_pop) result_reg <= fifo_dout;

      // Byte register changes only when a new start is about to be issued.
      if (state_next == ST_HDR)       tx_data_r <= HEADER;
      else if (state_next == ST_DATA) tx_data_r <= result_reg;

      if ((state == ST_HDR) || (state == ST_DATA)) tmo <= '0;
      else if (waiting && !tmo_hit)                tmo <= tmo + 1'b1;

      if (state != ST_GAP) gap_cnt <= '0;
      else if (!gap_hit)   gap_cnt <= gap_cnt + 1'b1;

      if (i_result_valid && !push_ok)          overflow_r <= 1'b1;
      if (waiting && !done_edge && tmo_hit)    tx_err_r   <= 1'b1;
    end
  end

  assign o_tx_data  = tx_data_r;
  assign o_tx_start = (state == ST_HDR) || (state == ST_DATA);
  assign o_busy     = (state != ST_IDLE) || !fifo_empty;
  assign o_full     = fifo_full;
  assign o_overflow = overflow_r;
  assign o_tx_err   = tx_err_r;

endmodule

// File: tb/tb_interfaz_tx_scheduler.sv
// tb/tb_interfaz_tx_scheduler.sv - scoreboard bench for the UART TX result scheduler
module tb_interfaz_tx_scheduler;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_result = '0;
  logic       i_result_valid = 1'b0;
  logic       man_done = 1'b0;
  logic       auto_done = 1'b0;
  logic       tx_done;
  logic [7:0] o_tx_data;
  logic       o_tx_start, o_busy, o_full, o_overflow, o_tx_err;
  logic [2:0] o_level;

  logic [7:0] t_result = '0;
  logic       t_valid = 1'b0;
  logic       t_done = 1'b0;
  logic [7:0] t_tx_data;
  logic       t_tx_start, t_busy, t_full, t_overflow, t_tx_err;
  logic [2:0] t_level;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  bit         auto_en = 1'b0;
  int         auto_cnt = 0;
  logic       start_prev = 1'b0;

  assign tx_done = man_done | auto_done;

  always #5 i_clk = ~i_clk;

  interfaz_tx_scheduler #(
    .NB_DATA(8), .FIFO_DEPTH(4), .SEND_HEADER(1), .HEADER(8'hA5),
    .TIMEOUT(64), .GAP_CYCLES(16)
  ) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_result(i_result), .i_result_valid(i_result_valid),
    .i_tx_done(tx_done), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_busy(o_busy),
    .o_full(o_full), .o_level(o_level), .o_overflow(o_overflow), .o_tx_err(o_tx_err)
  );

  interfaz_tx_scheduler #(
    .NB_DATA(8), .FIFO_DEPTH(4), .SEND_HEADER(1), .HEADER(8'hA5),
    .TIMEOUT(8), .GAP_CYCLES(16)
  ) u_tmo (
    .i_clk(i_clk), .i_rst(i_rst), .i_result(t_result), .i_result_valid(t_valid),
    .i_tx_done(t_done), .o_tx_data(t_tx_data), .o_tx_start(t_tx_start), .o_busy(t_busy),
    .o_full(t_full), .o_level(t_level), .o_overflow(t_overflow), .o_tx_err(t_tx_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic exp_frame(input logic [7:0] v);
    exp_q.push_back(8'hA5);
    exp_q.push_back(v);
  endtask

  task automatic do_push(input logic [7:0] v);
    i_result = v;
    i_result_valid = 1'b1;
    @(negedge i_clk);
    i_result_valid = 1'b0;
  endtask

  task automatic wait_start(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clk);
      if (o_tx_start) return;
    end
    checks++;
    failures++;
    $display("FAIL %s timeout waiting for tx_start after %0d cycles", name, budget);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0 && !o_busy) return;
    end
    checks++;
    failures++;
    $display("FAIL %s drain timeout, %0d bytes outstanding", name, exp_q.size());
  endtask

  // Monitor: every start pulse is matched against the next expected byte.
  always @(negedge i_clk) begin
    if (o_tx_start) begin
      checks++;
      if (start_prev) begin
        failures++;
        $display("FAIL start_pulse_width actual=2+ cycles required=1");
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_start actual=%0h required=none", o_tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (o_tx_data !== e) begin
          failures++;
          $display("FAIL tx_byte actual=%0h required=%0h", o_tx_data, e);
        end
      end
    end
    start_prev = o_tx_start;
  end

  // Automatic UART model: done pulses 10 cycles after each start.
  always @(negedge i_clk) begin
    if (auto_done) auto_done = 1'b0;
    if (auto_cnt > 0) begin
      auto_cnt--;
      if (auto_cnt == 0) auto_done = 1'b1;
    end
    if (auto_en && o_tx_start) auto_cnt = 10;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_tx_data", o_tx_data, 8'h00);
    chk("rst_tx_start", o_tx_start, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_level", o_level, 0);
    chk("rst_flags", {o_full, o_overflow, o_tx_err}, 3'b000);

    // Single result with header, fixed 3-cycle latency to first start
    exp_frame(8'h3C);
    i_result = 8'h3C;
    i_result_valid = 1'b1;
    @(negedge i_clk);
    i_result_valid = 1'b0;
    chk("t1_lat1_start", o_tx_start, 0);
    chk("t1_level", o_level, 1);
    chk("t1_busy", o_busy, 1);
    @(negedge i_clk);
    chk("t1_lat2_start", o_tx_start, 0);
    @(negedge i_clk);
    chk("t1_lat3_hdr", {o_tx_start, o_tx_data}, {1'b1, 8'hA5});
    repeat (10) @(negedge i_clk);
    man_done = 1'b1;
    @(negedge i_clk);
    chk("t1_data_start", {o_tx_start, o_tx_data}, {1'b1, 8'h3C});
    man_done = 1'b0;
    repeat (10) @(negedge i_clk);
    man_done = 1'b1;
    repeat (16) @(negedge i_clk);
    chk("t1_busy_in_gap", o_busy, 1);
    chk("t1_data_held", o_tx_data, 8'h3C);
    @(negedge i_clk);
    chk("t1_busy_after_gap", o_busy, 0);
    man_done = 1'b0;

    // tx_done held high: one edge only, WAIT_D must not advance
    exp_frame(8'h11);
    do_push(8'h11);
    wait_start("t3_hdr", 20);
    @(negedge i_clk);
    man_done = 1'b1;
    wait_start("t3_data", 20);
    repeat (20) @(negedge i_clk);
    chk("t3_busy_held", o_busy, 1);
    chk("t3_no_err", o_tx_err, 0);
    man_done = 1'b0;
    @(negedge i_clk);
    man_done = 1'b1;
    repeat (17) @(negedge i_clk);
    chk("t3_idle", o_busy, 0);
    man_done = 1'b0;

    // Stalled TX: fill queue, fifth push dropped
    exp_frame(8'h01);
    do_push(8'h01);
    wait_start("t2_hdr", 20);
    exp_frame(8'h10); exp_frame(8'h20); exp_frame(8'h30); exp_frame(8'h40);
    do_push(8'h10); do_push(8'h20); do_push(8'h30); do_push(8'h40);
    chk("t2_level_full", {o_full, o_level}, {1'b1, 3'd4});
    chk("t2_no_ovf_yet", o_overflow, 0);
    do_push(8'h50);
    chk("t2_level_after_drop", o_level, 4);
    chk("t2_overflow", o_overflow, 1);

    // Push while full on the pop cycle is accepted
    man_done = 1'b1;
    wait_start("t5_data0", 5);
    man_done = 1'b0;
    @(negedge i_clk);
    man_done = 1'b1;
    repeat (17) @(negedge i_clk);
    chk("t5_level_before", o_level, 4);
    exp_frame(8'h60);
    do_push(8'h60);
    chk("t5_level_same", o_level, 4);
    man_done = 1'b0;
    auto_en = 1'b1;
    wait_drain("t2_drain", 2000);
    chk("t2_no_err", o_tx_err, 0);
    auto_en = 1'b0;

    // Reset during WAIT_D with a queued entry
    exp_frame(8'h5A);
    do_push(8'h5A);
    wait_start("t6_hdr", 20);
    repeat (10) @(negedge i_clk);
    man_done = 1'b1;
    wait_start("t6_data", 5);
    man_done = 1'b0;
    @(negedge i_clk);
    do_push(8'h99);
    chk("t6_level_pre", o_level, 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("t6_rst_outputs", {o_tx_data, o_tx_start, o_busy, o_full, o_overflow, o_tx_err},
        {8'h00, 5'b00000});
    chk("t6_rst_level", o_level, 0);
    extra = 0;
    repeat (30) begin
      @(negedge i_clk);
      if (o_tx_start) extra++;
    end
    chk("t6_no_start", extra, 0);
    auto_en = 1'b1;
    exp_frame(8'h42);
    do_push(8'h42);
    wait_drain("t6_drain", 200);
    auto_en = 1'b0;
    chk("scoreboard_empty", exp_q.size(), 0);

    // Timeout on header byte (TIMEOUT=8 instance)
    t_result = 8'h77;
    t_valid = 1'b1;
    extra = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge i_clk);
      if (k == 1) t_valid = 1'b0;
      if (k == 3) chk("t4_hdr_start", {t_tx_start, t_tx_data}, {1'b1, 8'hA5});
      else if (t_tx_start) extra++;
      if (k == 11) chk("t4_err_before", t_tx_err, 0);
      if (k == 12) chk("t4_err_set", t_tx_err, 1);
      if (k == 27) chk("t4_busy_gap", t_busy, 1);
      if (k == 28) chk("t4_idle", t_busy, 0);
    end
    chk("t4_no_data_start", extra, 0);
    chk("t4_data_reg", t_tx_data, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
